// File: rtl/bc_msg_pkg.sv
// Shared widths, field offsets and message layout for the broadcast-message switch.
package bc_msg_pkg;

  localparam int DATA_LSB = 0;
  localparam int STRB_LSB = 32;
  localparam int ADDR_LSB = 36;

  // Byte-sized region in, word address width out.
  function automatic int calc_msg_addr_width(input int region_size);
    return $clog2(region_size) - 2;
  endfunction

  function automatic int calc_msg_width(input int addr_width);
    return 32 + 4 + addr_width;
  endfunction

  localparam int DEF_MSG_ADDR_WIDTH = calc_msg_addr_width(4048);

  typedef struct packed {
    logic [DEF_MSG_ADDR_WIDTH-1:0] addr;
    logic [3:0]                    strb;
    logic [31:0]                   data;
  } bc_msg_t;

endpackage

// File: rtl/bc_msg_fifo.sv
// Single-clock FIFO with registered count and full/empty flags; pushes are
// refused while full, even when a pop happens in the same cycle.
module bc_msg_fifo #(
  parameter int WIDTH = 46,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign w_do_push  = i_push & ~o_full;
  assign w_do_pop   = i_pop & ~o_empty;
  assign o_pop_data = r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/bc_msg_arbiter.sv
// Broadcast-message switch: per-core FIFOs, round-robin grant, one message per
// cycle to all cores. Define BC_MSG_SELF_MASK_EN to suppress the echo to the source.
module bc_msg_arbiter
  import bc_msg_pkg::*;
#(
  parameter int CORE_COUNT     = 16,
  parameter int CORE_ID_WIDTH  = $clog2(CORE_COUNT),
  parameter int BC_REGION_SIZE = 4048,
  parameter int MSG_ADDR_WIDTH = calc_msg_addr_width(BC_REGION_SIZE),
  parameter int MSG_WIDTH      = calc_msg_width(MSG_ADDR_WIDTH),
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst_n,
  input  logic [CORE_COUNT*MSG_WIDTH-1:0] core_msg,
  input  logic [CORE_COUNT-1:0]           core_msg_valid,
  output logic [CORE_COUNT-1:0]           core_msg_ready,
  output logic [MSG_WIDTH-1:0]            bc_msg,
  output logic [CORE_COUNT-1:0]           bc_msg_valid,
  output logic [CORE_ID_WIDTH-1:0]        bc_msg_src
);

  localparam int SW = CORE_ID_WIDTH + 1;

  logic                     r_rdy_en;
  logic [CORE_ID_WIDTH-1:0] r_last_grant;
  logic [MSG_WIDTH-1:0]     r_bc_msg;
  logic [CORE_ID_WIDTH-1:0] r_bc_src;
  logic                     r_bc_vld;

  logic [CORE_COUNT-1:0]    w_full;
  logic [CORE_COUNT-1:0]    w_empty;
  logic [CORE_COUNT-1:0]    w_push;
  logic [CORE_COUNT-1:0]    w_pop;
  logic [MSG_WIDTH-1:0]     w_pop_data [CORE_COUNT];
  logic                     w_grant_vld;
  logic [CORE_ID_WIDTH-1:0] w_grant_idx;
  logic [SW-1:0]            w_sum;
  logic [CORE_ID_WIDTH-1:0] w_cand;

  // Ready is held low through reset and the first edge after release.
  assign core_msg_ready = r_rdy_en ? ~w_full : '0;

  for (genvar g = 0; g < CORE_COUNT; g++) begin : g_core
    assign w_push[g] = core_msg_valid[g] & core_msg_ready[g];
    assign w_pop[g]  = w_grant_vld & (w_grant_idx == CORE_ID_WIDTH'(g));

    bc_msg_fifo #(
      .WIDTH (MSG_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .i_clk       (sys_clk),
      .i_rst_n     (sys_rst_n),
      .i_push      (w_push[g]),
      .i_push_data (core_msg[g*MSG_WIDTH +: MSG_WIDTH]),
      .i_pop       (w_pop[g]),
      .o_pop_data  (w_pop_data[g]),
      .o_full      (w_full[g]),
      .o_empty     (w_empty[g])
    );
  end

  // Round-robin search starting one past the previous grantee.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_sum       = '0;
    w_cand      = '0;
    for (int k = 0; k < CORE_COUNT; k++) begin
      w_sum = {1'b0, r_last_grant} + SW'(k + 1);
      if (w_sum >= SW'(CORE_COUNT)) w_sum = w_sum - SW'(CORE_COUNT);
      w_cand = w_sum[CORE_ID_WIDTH-1:0];
      if (!w_grant_vld && !w_empty[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rdy_en     <= 1'b0;
      r_last_grant <= CORE_ID_WIDTH'(CORE_COUNT - 1);
      r_bc_msg     <= '0;
      r_bc_src     <= '0;
      r_bc_vld     <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      r_bc_vld <= w_grant_vld;
      if (w_grant_vld) begin
        r_last_grant <= w_grant_idx;
        r_bc_msg     <= w_pop_data[w_grant_idx];
        r_bc_src     <= w_grant_idx;
      end
    end
  end

  assign bc_msg     = r_bc_msg;
  assign bc_msg_src = r_bc_src;

`ifdef BC_MSG_SELF_MASK_EN
  assign bc_msg_valid = {CORE_COUNT{r_bc_vld}} & ~(CORE_COUNT'(1) << r_bc_src);
`else
  assign bc_msg_valid = {CORE_COUNT{r_bc_vld}};
`endif

endmodule

// File: tb/tb_bc_msg_arbiter.sv
// Directed and random bench for bc_msg_arbiter against a queue-based reference
// model of the per-core buffers and the round-robin broadcast order.
module tb_bc_msg_arbiter;

  localparam int CC    = 16;
  localparam int IDW   = 4;
  localparam int AW    = 10;
  localparam int MW    = 32 + 4 + AW;
  localparam int DEPTH = 4;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic [CC*MW-1:0]  core_msg;
  logic [CC-1:0]     core_msg_valid;
  logic [CC-1:0]     core_msg_ready;
  logic [MW-1:0]     bc_msg;
  logic [CC-1:0]     bc_msg_valid;
  logic [IDW-1:0]    bc_msg_src;

  always #5 sys_clk = ~sys_clk;

  bc_msg_arbiter #(
    .CORE_COUNT     (CC),
    .BC_REGION_SIZE (4048),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .core_msg       (core_msg),
    .core_msg_valid (core_msg_valid),
    .core_msg_ready (core_msg_ready),
    .bc_msg         (bc_msg),
    .bc_msg_valid   (bc_msg_valid),
    .bc_msg_src     (bc_msg_src)
  );

  int checks = 0;
  int errors = 0;

  // Sources: messages each core still wants to send, head is on the bus.
  logic [MW-1:0] send_q [CC][$];
  // Reference model: buffered messages per core, expected broadcast queue.
  logic [MW-1:0] mq [CC][$];
  logic [MW-1:0] exp_q [$];
  int            m_lg;
  bit            m_en;
  bit            m_vld;
  int            m_src;
  logic [MW-1:0] m_msg;

  int obs_src [$];
  int exp_src [$];
  bit saw_low [CC];

  task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MW-1:0] mk(input int a, input int s, input logic [31:0] d);
    logic [31:0] av;
    logic [31:0] sv;
    av = a;
    sv = s;
    return {av[AW-1:0], sv[3:0], d};
  endfunction

  function automatic logic [CC-1:0] vmask(input int src);
    logic [CC-1:0] m;
    m = '1;
`ifdef BC_MSG_SELF_MASK_EN
    m[src] = 1'b0;
`endif
    return m;
  endfunction

  function automatic bit busy();
    for (int i = 0; i < CC; i++)
      if (send_q[i].size() > 0 || mq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive sources, check ready mid-cycle, advance model, check outputs.
  task automatic tick();
    logic [CC-1:0] exp_rdy;
    logic [CC-1:0] exp_vld;
    bit            acc [CC];
    int            g;
    int            idx;
    for (int i = 0; i < CC; i++) begin
      if (send_q[i].size() > 0) begin
        core_msg_valid[i]       = 1'b1;
        core_msg[i*MW +: MW]    = send_q[i][0];
      end else begin
        core_msg_valid[i]       = 1'b0;
      end
    end
    @(negedge sys_clk);
    for (int i = 0; i < CC; i++) exp_rdy[i] = m_en && (mq[i].size() != DEPTH);
    chk("core_msg_ready", MW'(core_msg_ready), MW'(exp_rdy));
    for (int i = 0; i < CC; i++) if (!core_msg_ready[i]) saw_low[i] = 1'b1;
    g = -1;
    for (int k = 0; k < CC; k++) begin
      idx = (m_lg + 1 + k) % CC;
      if (g < 0 && mq[idx].size() > 0) g = idx;
    end
    for (int i = 0; i < CC; i++) acc[i] = core_msg_valid[i] && exp_rdy[i];
    @(posedge sys_clk);
    #1;
    if (g >= 0) begin
      exp_q.push_back(mq[g].pop_front());
      m_src = g;
      m_lg  = g;
      m_vld = 1'b1;
    end else begin
      m_vld = 1'b0;
    end
    for (int i = 0; i < CC; i++) if (acc[i]) mq[i].push_back(send_q[i].pop_front());
    if (sys_rst_n) m_en = 1'b1;
    exp_vld = m_vld ? vmask(m_src) : '0;
    chk("bc_msg_valid", MW'(bc_msg_valid), MW'(exp_vld));
    if (m_vld) m_msg = exp_q.pop_front();
    chk("bc_msg", bc_msg, m_msg);
    chk("bc_msg_src", MW'(bc_msg_src), MW'(m_src));
    if (|bc_msg_valid) obs_src.push_back(int'(bc_msg_src));
  endtask

  // Asynchronous reset taken mid-cycle, held two edges, released mid-cycle.
  task automatic do_reset();
    sys_rst_n = 1'b0;
    for (int i = 0; i < CC; i++) begin
      send_q[i].delete();
      mq[i].delete();
    end
    exp_q.delete();
    core_msg_valid = '0;
    m_lg = CC - 1; m_en = 1'b0; m_vld = 1'b0; m_src = 0; m_msg = '0;
    #1;
    chk("rst_valid", MW'(bc_msg_valid), '0);
    chk("rst_ready", MW'(core_msg_ready), '0);
    chk("rst_msg", bc_msg, '0);
    chk("rst_src", MW'(bc_msg_src), '0);
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while (busy() && n < 500) begin
      tick();
      n++;
    end
    chk("drain_timeout", MW'(busy()), '0);
    tick();
  endtask

  task automatic chk_obs(input string tag);
    chk({tag, "_count"}, MW'(obs_src.size()), MW'(exp_src.size()));
    for (int k = 0; k < exp_src.size() && k < obs_src.size(); k++)
      chk(tag, MW'(obs_src[k]), MW'(exp_src[k]));
  endtask

  initial begin
    int cnt [CC];
    sys_rst_n      = 1'b1;
    core_msg       = '0;
    core_msg_valid = '0;
    #2;
    do_reset();

    // Single message from core 3: on the bus two cycles after valid.
    send_q[3].push_back(mk(5, 4'hF, 32'hDEADBEEF));
    tick();
    chk("single_early", MW'(bc_msg_valid), '0);
    tick();
    chk("single_msg", bc_msg, {10'd5, 4'hF, 32'hDEADBEEF});
    chk("single_src", MW'(bc_msg_src), MW'(3));
`ifdef BC_MSG_SELF_MASK_EN
    chk("single_vld", MW'(bc_msg_valid), MW'(16'hFFF7));
`else
    chk("single_vld", MW'(bc_msg_valid), MW'(16'hFFFF));
`endif
    tick();
    chk("single_drop", MW'(bc_msg_valid), '0);

    // Simultaneous burst 0,1,2, then 0,2 after last grant 2.
    obs_src.delete();
    for (int i = 0; i < 3; i++) send_q[i].push_back(mk(i + 1, i + 1, $urandom));
    drain();
    exp_src = '{0, 1, 2};
    chk_obs("rr_012");
    obs_src.delete();
    send_q[0].push_back(mk(20, 3, $urandom));
    send_q[2].push_back(mk(22, 12, $urandom));
    drain();
    exp_src = '{0, 2};
    chk_obs("rr_02");

    // Sole streamer: ready stays high, six outputs back to back.
    obs_src.delete();
    for (int i = 0; i < CC; i++) saw_low[i] = 1'b0;
    for (int j = 0; j < 6; j++) send_q[5].push_back(mk(j, 4'hA, $urandom));
    drain();
    exp_src = '{5, 5, 5, 5, 5, 5};
    chk_obs("stream5");
    chk("stream5_ready", MW'(saw_low[5]), '0);

    // All cores saturated from a fresh reset.
    do_reset();
    obs_src.delete();
    for (int i = 0; i < CC; i++) begin
      saw_low[i] = 1'b0;
      cnt[i]     = 0;
      for (int j = 0; j < 8; j++) send_q[i].push_back(mk($urandom_range(1023), $urandom_range(15), $urandom));
    end
    drain();
    chk("sat_total", MW'(obs_src.size()), MW'(8 * CC));
    for (int k = 0; k < 64 && k < obs_src.size(); k++) begin
      chk("sat_order", MW'(obs_src[k]), MW'(k % CC));
      cnt[obs_src[k]]++;
    end
    for (int i = 0; i < CC; i++) begin
      chk("sat_grants", MW'(cnt[i]), MW'(4));
      chk("sat_ready_fell", MW'(saw_low[i]), MW'(1));
    end

    // Reset in the middle of a burst: no stale output, core 0 first after release.
    for (int i = 0; i < CC; i++)
      for (int j = 0; j < 3; j++) send_q[i].push_back(mk($urandom_range(1023), $urandom_range(15), $urandom));
    repeat (6) tick();
    do_reset();
    obs_src.delete();
    send_q[9].push_back(mk(9, 4'h1, $urandom));
    send_q[0].push_back(mk(0, 4'h2, $urandom));
    drain();
    exp_src = '{0, 9};
    chk_obs("post_reset");

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < CC; i++)
        if ($urandom_range(3) == 0 && send_q[i].size() < 3)
          send_q[i].push_back(mk($urandom_range(1023), $urandom_range(15), $urandom));
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
